ntt_stage_scheduler: RTL
========================

// Module: ntt_stage_scheduler
// PURPOSE
//  Sequences a full in-place radix-2 DIT NTT over an N=2^LOG_N coefficient RAM. Sits directly upstream of dit_butterfly:
//  issues per-cycle read addresses (A,B) to the coefficient RAM and a twiddle index to the twiddle ROM, both synchronous
//  1-cycle reads. Emits write-back addresses delayed to line up with the butterfly's A_out/B_out.
//  Input data is assumed to be in bit-reversed order; output is natural order.
// PARAMETERS
//  LOG_N   8                                     log2 of transform size; N/2 butterflies per stage, LOG_N stages
//  BF_LAT  `MODRED_DELAY+`INTMUL_DELAY+1         dit_butterfly input-to-output latency in cycles
//  (local) D = BF_LAT+1                          issue-to-writeback delay (RAM read + butterfly)
// PORTS
//  clk        in   1        clock; all logic rising-edge
//  reset      in   1        asynchronous, active-low reset
//  start      in   1        begin transform; sampled only in IDLE
//  busy       out  1        high from the cycle after start until done
//  done       out  1        one-cycle pulse after final write-back
//  stage      out  LOG_N    current stage index s
//  rd_en      out  1        coefficient RAM and twiddle ROM read strobe
//  rd_addr_a  out  LOG_N    RAM address of butterfly A operand
//  rd_addr_b  out  LOG_N    RAM address of butterfly B operand
//  tw_addr    out  LOG_N-1  twiddle ROM index
//  bf_mode    out  1        to dit_butterfly mode; constant 0 (butterfly)
//  wr_en      out  1        write-back strobe for A_out/B_out
//  wr_addr_a  out  LOG_N    write address for A_out
//  wr_addr_b  out  LOG_N    write address for B_out
// BEHAVIOUR
//  - Reset: state=IDLE; busy, done, rd_en, wr_en, bf_mode=0; all addresses, stage, counters=0; delay line cleared.
//  - FSM IDLE -> RUN on start. RUN issues one butterfly per cycle (rd_en=1), j=0..N/2-1.
//    After j=N/2-1: RUN -> DRAIN.
//    DRAIN holds rd_en=0 for exactly D cycles so that stage s writes land before stage s+1 reads (RAW hazard).
//    At end of DRAIN: if s<LOG_N-1 then s++, j=0, -> RUN; else -> DONE.
//    DONE asserts done for 1 cycle, busy=0, -> IDLE.
//  - Address math, stage s, half=2^s: k=j&(half-1); g=j>>s.
//    rd_addr_a=(g<<(s+1))|k; rd_addr_b=rd_addr_a+half; tw_addr=k<<(LOG_N-1-s). All unsigned, no overflow by construction.
//  - Write-back: {wr_en,wr_addr_a,wr_addr_b} equals {rd_en,rd_addr_a,rd_addr_b} delayed exactly D cycles.
//    The delay line shifts every cycle regardless of state.
//  - Stage period = N/2+D cycles. With start at cycle 0, done is high in cycle LOG_N*(N/2+D)+1.
//  - start while busy or in DONE: ignored.
//  - reset asserted mid-transform: immediate abort to reset values; in-flight writes are discarded (wr_en forced 0).
//  - Addresses hold their last value when rd_en=0; consumers qualify them with the strobes.
// CONFIGURATION
//  NTT_SCHED_STALL_EN: adds input port stall (1 bit).
//  - With the macro: stall=1 in RUN freezes j and forces rd_en=0 (a bubble enters the delay line). DRAIN is unaffected.
//  - Without the macro: no stall port; issue is unconditional every RUN cycle.
// STRUCTURE
//  - defines.v: BF_SCHED_D (derived from `MODRED_DELAY, `INTMUL_DELAY) and the FSM state encodings.
//  - Sub-module addr_delay_line: shift register of width 1+2*LOG_N, depth D, async active-low clear.
//  - Address generation and FSM stay in this module.
// TESTING
//  All scenarios use LOG_N=3, BF_LAT=4 (D=5).
//  - Stage 0, start at cycle 0 -> rd_en cycles 1..4; (a,b,tw) = (0,1,0),(2,3,0),(4,5,0),(6,7,0).
//  - Stage 1 -> rd_en cycles 10..13; (0,2,0),(1,3,2),(4,6,0),(5,7,2).
//    Stage 2 -> rd_en cycles 19..22; (0,4,0),(1,5,1),(2,6,2),(3,7,3).
//  - Alignment: wr_en cycles 6..9, 15..18, 24..27, with addresses matching the reads 5 cycles earlier.
//    done=1 only in cycle 28; busy=1 in cycles 1..27.
//  - start pulsed again at cycle 12 -> ignored; sequence identical to the above.
//  - reset pulled low at cycle 16 -> all outputs 0 at once. New start after release -> full clean transform from stage 0.
//  - End-to-end: with the macro defined, drive stall=1 in cycles 2..3 -> stage 0 issue spans cycles 1..6, done shifts +2.
//    Same bench: dit_butterfly + RAMs vs a software NTT, q=4244570881, N=8 -> bit-exact outputs.

Source files
------------

// File: rtl/ntt_stage_scheduler_pkg.sv
// Shared types and helpers for the NTT stage scheduler.
// BF_LAT_DEF follows the butterfly's reducer/multiplier depths.
package ntt_stage_scheduler_pkg;

  localparam int MODRED_DELAY_DEF = 2;
  localparam int INTMUL_DELAY_DEF = 1;
  localparam int BF_LAT_DEF       = MODRED_DELAY_DEF + INTMUL_DELAY_DEF + 1;

  localparam int LOG_N_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  // Issue-to-writeback delay: one cycle of RAM read plus the butterfly.
  function automatic int sched_delay(input int bf_lat);
    return bf_lat + 1;
  endfunction

endpackage

// File: rtl/ntt_stage_scheduler_if.sv
// Control/address bus between the NTT stage scheduler and the
// coefficient RAM, twiddle ROM and dit_butterfly.
// NTT_SCHED_STALL_EN adds the stall input.
interface ntt_stage_scheduler_if #(
  parameter int LOG_N = 8
);
`ifdef NTT_SCHED_STALL_EN
  logic               stall;
`endif
  logic               start;
  logic               busy;
  logic               done;
  logic [LOG_N-1:0]   stage;
  logic               rd_en;
  logic [LOG_N-1:0]   rd_addr_a;
  logic [LOG_N-1:0]   rd_addr_b;
  logic [LOG_N-2:0]   tw_addr;
  logic               bf_mode;
  logic               wr_en;
  logic [LOG_N-1:0]   wr_addr_a;
  logic [LOG_N-1:0]   wr_addr_b;

  modport master (
`ifdef NTT_SCHED_STALL_EN
    input  stall,
`endif
    input  start,
    output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           bf_mode, wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
`ifdef NTT_SCHED_STALL_EN
    output stall,
`endif
    output start,
    input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           bf_mode, wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/ntt_stage_scheduler_addr_delay_line.sv
// Fixed-depth shift register carrying {rd_en, addr_a, addr_b} forward so the
// write-back strobe/addresses line up with the butterfly outputs.
module ntt_stage_scheduler_addr_delay_line #(
  parameter int W     = 17,
  parameter int DEPTH = 5
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] pipe_q [DEPTH];

  // Shift every cycle; async clear drops any in-flight write-back.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign q_o = pipe_q[DEPTH-1];
endmodule

// File: rtl/ntt_stage_scheduler.sv
// In-place radix-2 DIT NTT sequencer: one butterfly issue per RUN cycle,
// a DRAIN gap of D cycles between stages to clear the RAW hazard, and
// write-back addresses delayed by D to meet the butterfly outputs.
// Optional feature macro: NTT_SCHED_STALL_EN (adds bus.stall).
module ntt_stage_scheduler
  import ntt_stage_scheduler_pkg::*;
#(
  parameter int LOG_N  = LOG_N_DEF,
  parameter int BF_LAT = BF_LAT_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  ntt_stage_scheduler_if.master   bus
);
  localparam int D     = sched_delay(BF_LAT);
  localparam int CNT_W = (D > 1) ? $clog2(D) : 1;
  localparam int TW_W  = LOG_N - 1;
  localparam logic [LOG_N-1:0] HALF_N     = LOG_N'(1) << (LOG_N - 1);
  localparam logic [LOG_N-1:0] LAST_STAGE = LOG_N'(LOG_N - 1);

  function automatic logic [LOG_N-1:0] f_addr_a(input logic [LOG_N-1:0] s,
                                                input logic [LOG_N-1:0] j);
    logic [LOG_N-1:0] half, k, g;
    half = LOG_N'(1) << s;
    k    = j & (half - LOG_N'(1));
    g    = j >> s;
    return (g << (s + LOG_N'(1))) | k;
  endfunction

  function automatic logic [TW_W-1:0] f_tw(input logic [LOG_N-1:0] s,
                                           input logic [LOG_N-1:0] j);
    logic [LOG_N-1:0] half, k;
    half = LOG_N'(1) << s;
    k    = j & (half - LOG_N'(1));
    return TW_W'(k << (LOG_N'(LOG_N - 1) - s));
  endfunction

  sched_state_e       state_q;
  logic [LOG_N-1:0]   stage_q, j_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q, done_q, rd_en_q;
  logic [LOG_N-1:0]   rd_addr_a_q, rd_addr_b_q;
  logic [TW_W-1:0]    tw_addr_q;
  logic [LOG_N-1:0]   sel_s_d, sel_j_d, addr_a_d, addr_b_d;
  logic [TW_W-1:0]    tw_d;
  logic               stall_w;

`ifdef NTT_SCHED_STALL_EN
  assign stall_w = bus.stall;
`else
  assign stall_w = 1'b0;
`endif

  // Operand/twiddle addresses of the butterfly that issues on the next edge.
  always_comb begin
    sel_s_d = stage_q;
    sel_j_d = j_q;
    case (state_q)
      ST_IDLE:  begin sel_s_d = '0;                  sel_j_d = '0; end
      ST_DRAIN: begin sel_s_d = stage_q + LOG_N'(1); sel_j_d = '0; end
      default:  ;
    endcase
    addr_a_d = f_addr_a(sel_s_d, sel_j_d);
    addr_b_d = addr_a_d + (LOG_N'(1) << sel_s_d);
    tw_d     = f_tw(sel_s_d, sel_j_d);
  end

  // Stage sequencing FSM with registered strobes and addresses; j_q is the
  // index of the next butterfly still to issue in the current stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      stage_q     <= '0;
      j_q         <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_a_q <= '0;
      rd_addr_b_q <= '0;
      tw_addr_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_q     <= ST_RUN;
            busy_q      <= 1'b1;
            stage_q     <= '0;
            j_q         <= LOG_N'(1);
            rd_en_q     <= 1'b1;
            rd_addr_a_q <= addr_a_d;
            rd_addr_b_q <= addr_b_d;
            tw_addr_q   <= tw_d;
          end
        end
        ST_RUN: begin
          if (j_q == HALF_N) begin
            state_q <= ST_DRAIN;
            rd_en_q <= 1'b0;
            cnt_q   <= '0;
          end else if (stall_w) begin
            rd_en_q <= 1'b0;
          end else begin
            j_q         <= j_q + LOG_N'(1);
            rd_en_q     <= 1'b1;
            rd_addr_a_q <= addr_a_d;
            rd_addr_b_q <= addr_b_d;
            tw_addr_q   <= tw_d;
          end
        end
        ST_DRAIN: begin
          if (cnt_q == CNT_W'(D - 1)) begin
            if (stage_q == LAST_STAGE) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q     <= ST_RUN;
              stage_q     <= stage_q + LOG_N'(1);
              j_q         <= LOG_N'(1);
              rd_en_q     <= 1'b1;
              rd_addr_a_q <= addr_a_d;
              rd_addr_b_q <= addr_b_d;
              tw_addr_q   <= tw_d;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  ntt_stage_scheduler_addr_delay_line #(
    .W     (1 + 2 * LOG_N),
    .DEPTH (D)
  ) u_wb_delay (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    ({rd_en_q, rd_addr_a_q, rd_addr_b_q}),
    .q_o    ({bus.wr_en, bus.wr_addr_a, bus.wr_addr_b})
  );

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.stage     = stage_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr_a = rd_addr_a_q;
  assign bus.rd_addr_b = rd_addr_b_q;
  assign bus.tw_addr   = tw_addr_q;
  assign bus.bf_mode   = 1'b0;
endmodule
